axi_burst_master: RTL and testbench

//  Synthesizable, parametrised AXI burst master driven by a simple command port; replaces the

---
 rtl/axi_pkg.sv | 28 ++
 rtl/axi_burst_master_if.sv | 44 ++++
 rtl/axi_mst_beat_cnt.sv | 23 ++
 rtl/axi_burst_master.sv | 179 +++++++++++++++++
 tb/tb_axi_burst_master.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared response/state types and helpers for the AXI burst master
package axi_pkg;

  localparam int AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } mst_state_e;

  // Encodings are ordered by severity, so the worst response is the larger code.
  function automatic resp_e resp_worst(input resp_e a, input resp_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// rtl/axi_burst_master_if.sv - AXI AW/W/B/AR/R channel bundle with master/slave views
interface axi_burst_master_if import axi_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]    AWADDR;
  logic [AXI_LEN_W-1:0] AWLEN;
  logic                 AWVALID;
  logic                 AWREADY;
  logic [DATA_W-1:0]    WDATA;
  logic                 WLAST;
  logic                 WVALID;
  logic                 WREADY;
  logic [1:0]           BRESP;
  logic                 BVALID;
  logic                 BREADY;
  logic [ADDR_W-1:0]    ARADDR;
  logic [AXI_LEN_W-1:0] ARLEN;
  logic                 ARVALID;
  logic                 ARREADY;
  logic [DATA_W-1:0]    RDATA;
  logic                 RLAST;
  logic [1:0]           RRESP;
  logic                 RVALID;
  logic                 RREADY;

  modport master (
    output AWADDR, AWLEN, AWVALID, input AWREADY,
    output WDATA, WLAST, WVALID,   input WREADY,
    input  BRESP, BVALID,          output BREADY,
    output ARADDR, ARLEN, ARVALID, input ARREADY,
    input  RDATA, RLAST, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWVALID, output AWREADY,
    input  WDATA, WLAST, WVALID,   output WREADY,
    output BRESP, BVALID,          input BREADY,
    input  ARADDR, ARLEN, ARVALID, output ARREADY,
    output RDATA, RLAST, RRESP, RVALID, input RREADY
  );

endinterface

// File: rtl/axi_mst_beat_cnt.sv
// rtl/axi_mst_beat_cnt.sv - burst beat counter with last-beat compare, shared by W and R
module axi_mst_beat_cnt import axi_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_inc,
  input  logic [AXI_LEN_W-1:0] i_len,
  output logic                 o_is_last
);

  logic [AXI_LEN_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_is_last = (r_cnt == i_len);

endmodule

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-command AXI INCR burst master; AXI_MST_TIMEOUT_EN adds a no-progress watchdog
module axi_burst_master import axi_pkg::*; #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_LEN     = 256,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_rnw,
  input  logic [ADDR_W-1:0]    i_cmd_addr,
  input  logic [AXI_LEN_W-1:0] i_cmd_len,
  input  logic [DATA_W-1:0]    i_wr_data,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  output logic [DATA_W-1:0]    o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_rd_last,
  input  logic                 i_rd_ready,
  output logic                 o_done_valid,
  output logic [1:0]           o_done_resp,
  output logic                 o_done_proto,
  output logic                 o_busy,
  axi_burst_master_if.master   m_axi
);

  mst_state_e           r_state;
  mst_state_e           w_state_nxt;
  logic [ADDR_W-1:0]    r_addr;
  logic [AXI_LEN_W-1:0] r_len;
  logic [AXI_LEN_W-1:0] w_len_clamped;
  resp_e                r_resp;
  logic                 r_proto;
  logic                 w_accept;
  logic                 w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic                 w_cnt_last;
  logic                 w_timeout;

  assign w_len_clamped = (int'(i_cmd_len) >= MAX_LEN) ? AXI_LEN_W'(MAX_LEN - 1) : i_cmd_len;
  assign w_accept      = (r_state == ST_IDLE) && i_cmd_valid;
  assign w_aw_hs       = (r_state == ST_AW) && m_axi.AWREADY;
  assign w_w_hs        = (r_state == ST_W) && i_wr_valid && m_axi.WREADY;
  assign w_b_hs        = (r_state == ST_B) && m_axi.BVALID;
  assign w_ar_hs       = (r_state == ST_AR) && m_axi.ARREADY;
  assign w_r_hs        = (r_state == ST_R) && m_axi.RVALID && i_rd_ready;

  axi_mst_beat_cnt u_beat_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_inc     (w_w_hs || w_r_hs),
    .i_len     (r_len),
    .o_is_last (w_cnt_last)
  );

`ifdef AXI_MST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_waiting;
  logic            w_any_hs;

  assign w_waiting = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_any_hs  = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;
  assign w_timeout = w_waiting && !w_any_hs && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !w_waiting || w_any_hs) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_resp  <= RESP_OKAY;
      r_proto <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr  <= i_cmd_addr;
        r_len   <= w_len_clamped;
        r_resp  <= RESP_OKAY;
        r_proto <= 1'b0;
      end
      if (w_b_hs) begin
        r_resp <= resp_worst(r_resp, resp_e'(m_axi.BRESP));
      end
      // RLAST is only advisory: the beat count decides the burst end, a disagreement is flagged.
      if (w_r_hs) begin
        r_resp <= resp_worst(r_resp, resp_e'(m_axi.RRESP));
        if (m_axi.RLAST != w_cnt_last) begin
          r_proto <= 1'b1;
        end
      end
      if (w_timeout) begin
        r_resp  <= RESP_SLVERR;
        r_proto <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_cmd_ready   = 1'b0;
    o_busy        = 1'b0;
    o_done_valid  = 1'b0;
    o_done_resp   = 2'b00;
    o_done_proto  = 1'b0;
    o_wr_ready    = 1'b0;
    o_rd_valid    = 1'b0;
    o_rd_last     = 1'b0;
    o_rd_data     = m_axi.RDATA;
    m_axi.AWADDR  = r_addr;
    m_axi.AWLEN   = r_len;
    m_axi.AWVALID = 1'b0;
    m_axi.WDATA   = i_wr_data;
    m_axi.WLAST   = 1'b0;
    m_axi.WVALID  = 1'b0;
    m_axi.BREADY  = 1'b0;
    m_axi.ARADDR  = r_addr;
    m_axi.ARLEN   = r_len;
    m_axi.ARVALID = 1'b0;
    m_axi.RREADY  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) w_state_nxt = i_cmd_rnw ? ST_AR : ST_AW;
      end
      ST_AW: begin
        o_busy        = 1'b1;
        m_axi.AWVALID = 1'b1;
        if (m_axi.AWREADY) w_state_nxt = ST_W;
      end
      ST_W: begin
        o_busy       = 1'b1;
        m_axi.WVALID = i_wr_valid;
        m_axi.WLAST  = w_cnt_last;
        o_wr_ready   = m_axi.WREADY;
        if (w_w_hs && w_cnt_last) w_state_nxt = ST_B;
      end
      ST_B: begin
        o_busy       = 1'b1;
        m_axi.BREADY = 1'b1;
        if (m_axi.BVALID) w_state_nxt = ST_DONE;
      end
      ST_AR: begin
        o_busy        = 1'b1;
        m_axi.ARVALID = 1'b1;
        if (m_axi.ARREADY) w_state_nxt = ST_R;
      end
      ST_R: begin
        o_busy       = 1'b1;
        m_axi.RREADY = i_rd_ready;
        o_rd_valid   = m_axi.RVALID;
        o_rd_last    = w_cnt_last;
        if (w_r_hs && w_cnt_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done_valid = 1'b1;
        o_done_resp  = r_resp;
        o_done_proto = r_proto;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_timeout) w_state_nxt = ST_DONE;
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - directed and randomized checks of axi_burst_master against a burst-level model
module tb_axi_burst_master;

  localparam int MAX_LEN = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last, rd_ready;
  logic        done_valid, done_proto, busy;
  logic [1:0]  done_resp;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  axi_burst_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi_burst_master #(.ADDR_W(32), .DATA_W(32), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rnw(cmd_rnw),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_rd_last(rd_last), .i_rd_ready(rd_ready),
    .o_done_valid(done_valid), .o_done_resp(done_resp), .o_done_proto(done_proto),
    .o_busy(busy), .m_axi(axi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input bit rnw, input logic [31:0] addr, input logic [7:0] len, output int c0);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("busy_idle", busy, 0);
    c0 = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic addr_phase(input bit rnw, input logic [31:0] addr, input logic [7:0] elen, input int stall);
    for (int k = 0; k <= stall; k++) begin
      if (rnw) axi.ARREADY = (k == stall);
      else     axi.AWREADY = (k == stall);
      @(negedge clk);
      chk("axvalid", rnw ? axi.ARVALID : axi.AWVALID, 1);
      chk("axaddr", rnw ? axi.ARADDR : axi.AWADDR, addr);
      chk("axlen", rnw ? axi.ARLEN : axi.AWLEN, elen);
      chk("busy_addr", busy, 1);
      @(posedge clk); #1;
    end
    axi.AWREADY = 1'b0; axi.ARREADY = 1'b0;
  endtask

  task automatic w_phase(input logic [7:0] elen, input bit rnd);
    logic [31:0] d[$];
    int i = 0;
    int guard = 0;
    bit hs;
    for (int j = 0; j <= int'(elen); j++) d.push_back($urandom);
    while (i <= int'(elen) && guard < 500) begin
      wr_valid   = rnd ? (($urandom % 4) != 0) : 1'b1;
      axi.WREADY = rnd ? (($urandom % 4) != 0) : 1'b1;
      wr_data    = d[i];
      @(negedge clk);
      chk("wvalid", axi.WVALID, wr_valid);
      chk("wr_ready", wr_ready, axi.WREADY);
      if (wr_valid) begin
        chk("wdata", axi.WDATA, d[i]);
        chk("wlast", axi.WLAST, (i == int'(elen)));
      end
      hs = wr_valid && axi.WREADY;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    chk("w_beats", i, int'(elen) + 1);
    wr_valid = 1'b0; axi.WREADY = 1'b0;
  endtask

  task automatic b_phase(input int stall, input logic [1:0] bresp);
    for (int k = 0; k <= stall; k++) begin
      axi.BVALID = (k == stall);
      axi.BRESP  = bresp;
      @(negedge clk);
      chk("bready", axi.BREADY, 1);
      chk("busy_b", busy, 1);
      @(posedge clk); #1;
    end
    axi.BVALID = 1'b0;
  endtask

  // Model: beats in order, rd_last on beat len, worst response = largest code, RLAST disagreement -> proto.
  task automatic r_phase(input logic [7:0] elen, input int rdy_mode, input bit rnd_valid, input bit rnd_resp,
                         input int slverr_beat, input int rlast_beat, output logic [1:0] worst, output bit proto);
    logic [31:0] d[$];
    logic [1:0]  rr[$];
    int i = 0;
    int guard = 0;
    bit hs;
    worst = 2'b00;
    for (int j = 0; j <= int'(elen); j++) begin
      d.push_back($urandom);
      rr.push_back(rnd_resp ? 2'($urandom % 4) : ((j == slverr_beat) ? 2'b10 : 2'b00));
      if (rr[j] > worst) worst = rr[j];
    end
    proto = (rlast_beat >= 0) && (rlast_beat != int'(elen));
    while (i <= int'(elen) && guard < 500) begin
      axi.RVALID = rnd_valid ? (($urandom % 4) != 0) : 1'b1;
      axi.RDATA  = d[i];
      axi.RRESP  = rr[i];
      axi.RLAST  = (rlast_beat < 0) ? (i == int'(elen)) : (i == rlast_beat);
      rd_ready   = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (guard % 2 == 0) : (($urandom % 3) != 0);
      @(negedge clk);
      chk("rready", axi.RREADY, rd_ready);
      chk("rd_valid", rd_valid, axi.RVALID);
      if (axi.RVALID) begin
        chk("rd_data", rd_data, d[i]);
        chk("rd_last", rd_last, (i == int'(elen)));
      end
      hs = axi.RVALID && rd_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    chk("r_beats", i, int'(elen) + 1);
    axi.RVALID = 1'b1; axi.RLAST = 1'b1; rd_ready = 1'b1;
  endtask

  task automatic done_chk(input logic [1:0] resp, input bit proto, input int c0, input int lat);
    @(negedge clk);
    chk("done_valid", done_valid, 1);
    chk("done_resp", done_resp, resp);
    chk("done_proto", done_proto, proto);
    chk("busy_done", busy, 0);
    chk("cmd_ready_done", cmd_ready, 0);
    chk("rready_done", axi.RREADY, 0);
    chk("rd_valid_done", rd_valid, 0);
    if (lat >= 0) chk("latency", cyc - c0, lat);
    @(posedge clk); #1;
    axi.RVALID = 1'b0; axi.RLAST = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", done_valid, 0);
    chk("cmd_ready_after", cmd_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input int astall, input int bstall,
                           input bit rnd, input logic [1:0] bresp, input bit chk_lat);
    int c0;
    logic [7:0] elen;
    elen = (int'(len) >= MAX_LEN) ? 8'(MAX_LEN - 1) : len;
    send_cmd(1'b0, addr, len, c0);
    addr_phase(1'b0, addr, elen, astall);
    w_phase(elen, rnd);
    b_phase(bstall, bresp);
    done_chk(bresp, 1'b0, c0, chk_lat ? (astall + int'(elen) + 4 + bstall) : -1);
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input int astall, input int rdy_mode,
                          input bit rnd_valid, input bit rnd_resp, input int slverr_beat, input int rlast_beat,
                          input bit chk_lat);
    int c0;
    logic [7:0] elen;
    logic [1:0] worst;
    bit proto;
    elen = (int'(len) >= MAX_LEN) ? 8'(MAX_LEN - 1) : len;
    send_cmd(1'b1, addr, len, c0);
    addr_phase(1'b1, addr, elen, astall);
    r_phase(elen, rdy_mode, rnd_valid, rnd_resp, slverr_beat, rlast_beat, worst, proto);
    done_chk(worst, proto, c0, chk_lat ? (astall + int'(elen) + 3) : -1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BRESP = 2'b00; axi.BVALID = 1'b0; axi.ARREADY = 1'b0;
    axi.RDATA = '0; axi.RLAST = 1'b0; axi.RRESP = 2'b00; axi.RVALID = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_awvalid", axi.AWVALID, 0);
    chk("rst_arvalid", axi.ARVALID, 0);
    chk("rst_wvalid_wlast", {axi.WVALID, axi.WLAST}, 2'b00);
    chk("rst_bready_rready", {axi.BREADY, axi.RREADY}, 2'b00);
    chk("rst_done", {done_valid, done_resp, done_proto}, 4'h0);
    chk("rst_addr_len", {axi.AWADDR, axi.AWLEN}, 40'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_write(32'h100, 8'd3, 0, 0, 1'b0, 2'b00, 1'b1);
    run_read(32'h40, 8'd0, 5, 0, 1'b0, 1'b0, -1, -1, 1'b1);
    run_read(32'h80, 8'd3, 0, 1, 1'b0, 1'b0, 2, -1, 1'b0);
    run_read(32'hC0, 8'd3, 0, 0, 1'b0, 1'b0, -1, 1, 1'b1);

    begin : rst_mid_burst
      int c0;
      send_cmd(1'b0, 32'h200, 8'd7, c0);
      addr_phase(1'b0, 32'h200, 8'd7, 0);
      wr_valid = 1'b1; axi.WREADY = 1'b1;
      for (int j = 0; j < 2; j++) begin
        wr_data = j;
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_wvalid", axi.WVALID, 0);
      chk("rst_mid_wr_ready", wr_ready, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_cmd_ready", cmd_ready, 1);
      chk("rst_mid_awaddr", axi.AWADDR, 0);
      wr_valid = 1'b0; axi.WREADY = 1'b0;
      @(posedge clk); #1;
    end

    run_write(32'h800, 8'd200, 1, 2, 1'b0, 2'b11, 1'b1);

    for (int t = 0; t < 12; t++) begin
      logic [31:0] a;
      logic [7:0]  l;
      int          s;
      a = $urandom & 32'hFFFF_FFFC;
      l = 8'($urandom % 12);
      s = $urandom % 3;
      if (($urandom % 2) == 1) run_read(a, l, s, 2, 1'b1, 1'b1, -1, -1, 1'b0);
      else                     run_write(a, l, s, $urandom % 3, 1'b1, 2'($urandom % 4), 1'b0);
    end

`ifdef AXI_MST_TIMEOUT_EN
    begin : timeout_b
      int c0;
      int n;
      send_cmd(1'b0, 32'h300, 8'd0, c0);
      addr_phase(1'b0, 32'h300, 8'd0, 0);
      w_phase(8'd0, 1'b0);
      n = 0;
      @(negedge clk);
      while (!done_valid && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("to_wait_cycles", n, 16);
      chk("to_resp", done_resp, 2'b10);
      chk("to_proto", done_proto, 1);
      chk("to_bready", axi.BREADY, 0);
      @(posedge clk); #1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
